// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink driver: channel FSM encoding and counter widths.
package led_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int PWM_W  = 4;
  localparam int BCNT_W = 4;

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: IDLE/ON/OFF blink FSM with phase, blink and saturating pending counters.
// Exposes next-cycle lit/busy/overflow so the top can register its outputs with 1-cycle latency.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int TIME_ON   = 5_000_000,
  parameter int TIME_OFF  = 5_000_000,
  parameter int BLINK_NUM = 2,
  parameter int PEND_W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  output logic on_nxt,
  output logic busy_nxt,
  output logic ovf_nxt
);

  localparam logic [DATA_W-1:0] ON_LAST  = DATA_W'(TIME_ON - 1);
  localparam logic [DATA_W-1:0] OFF_LAST = DATA_W'(TIME_OFF - 1);
  localparam logic [BCNT_W-1:0] B_LAST   = BCNT_W'(BLINK_NUM - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   cnt, cnt_nxt;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
  logic [PEND_W-1:0]   pend, pend_nxt;
  logic                decide;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bcnt  <= bcnt_nxt;
      pend  <= pend_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bcnt_nxt  = bcnt;
    pend_nxt  = pend;
    ovf_nxt   = 1'b0;
    decide    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (ev) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
          bcnt_nxt  = '0;
        end
      end
      ST_ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (cnt == OFF_LAST) begin
          cnt_nxt = '0;
          if (bcnt < B_LAST) begin
            bcnt_nxt  = bcnt + 1'b1;
            state_nxt = ST_ON;
          end else begin
            // Sequence end: a queued or live event chains the next sequence with no gap.
            decide = 1'b1;
            if (pend != '0 || ev) begin
              state_nxt = ST_ON;
              bcnt_nxt  = '0;
              if (pend != '0 && !ev) pend_nxt = pend - 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (ev && state != ST_IDLE && !decide) begin
      if (pend == PEND_MAX) ovf_nxt  = 1'b1;
      else                  pend_nxt = pend + 1'b1;
    end
  end

  assign on_nxt   = (state_nxt == ST_ON);
  assign busy_nxt = (state_nxt != ST_IDLE);

endmodule

// File: rtl/led_blink_driver.sv
// Multi-channel active-low LED blink driver with per-channel event queueing.
// Optional LED_BLINK_PWM_EN dims the ON phase with a shared 4-bit PWM counter.
module led_blink_driver
  import led_blink_pkg::*;
#(
  parameter int LED_W     = 4,
  parameter int DATA_W    = 24,
  parameter int TIME_ON   = 5_000_000,
  parameter int TIME_OFF  = 5_000_000,
  parameter int BLINK_NUM = 2,
  parameter int PEND_W    = 3,
  parameter int PWM_DUTY  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] ev_in,
  output logic [LED_W-1:0] led_n,
  output logic [LED_W-1:0] busy,
  output logic [LED_W-1:0] pend_ovf
);

  logic [LED_W-1:0] on_nxt;
  logic [LED_W-1:0] busy_nxt;
  logic [LED_W-1:0] ovf_nxt;
  logic [LED_W-1:0] lit_nxt;

  for (genvar i = 0; i < LED_W; i++) begin : g_chan
    led_blink_chan #(
      .DATA_W   (DATA_W),
      .TIME_ON  (TIME_ON),
      .TIME_OFF (TIME_OFF),
      .BLINK_NUM(BLINK_NUM),
      .PEND_W   (PEND_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ev      (ev_in[i]),
      .on_nxt  (on_nxt[i]),
      .busy_nxt(busy_nxt[i]),
      .ovf_nxt (ovf_nxt[i])
    );
  end

`ifdef LED_BLINK_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] pwm_nxt;
  logic             pwm_lit;

  assign pwm_nxt = pwm_cnt + 1'b1;
  // Compared against the value the counter will hold while the registered LED is visible.
  assign pwm_lit = ({1'b0, pwm_nxt} < (PWM_W + 1)'(PWM_DUTY));
  assign lit_nxt = on_nxt & {LED_W{pwm_lit}};

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_nxt;
  end
`else
  localparam int unused_pwm_duty = PWM_DUTY;
  assign lit_nxt = on_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      led_n    <= '1;
      busy     <= '0;
      pend_ovf <= '0;
    end else begin
      led_n    <= ~lit_nxt;
      busy     <= busy_nxt;
      pend_ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Scoreboard bench for led_blink_driver (TIME_ON=4, TIME_OFF=3, BLINK_NUM=2, PEND_W=2).
module tb_led_blink_driver;

  localparam int N_CYC = 250;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ev_in;
  logic [3:0] led_n;
  logic [3:0] busy;
  logic [3:0] pend_ovf;

  always #5 clk = ~clk;

  led_blink_driver #(
    .LED_W    (4),
    .DATA_W   (24),
    .TIME_ON  (4),
    .TIME_OFF (3),
    .BLINK_NUM(2),
    .PEND_W   (2),
    .PWM_DUTY (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_in   (ev_in),
    .led_n   (led_n),
    .busy    (busy),
    .pend_ovf(pend_ovf)
  );

  typedef struct {
    int ch;
    int s;
    int e;
  } seq_t;

  typedef struct {
    int         cyc;
    logic [11:0] val;
  } exp_t;

  seq_t seq_q[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add_seq(input int ch, input int s, input int e);
    seq_t t;
    t.ch = ch;
    t.s  = s;
    t.e  = e;
    seq_q.push_back(t);
  endtask

  function automatic logic rst_at(int k);
    return (k <= 1) || (k == 176);
  endfunction

  function automatic logic [3:0] ev_at(int k);
    logic [3:0] m;
    m = '0;
    if (k == 5 || k == 30 || k == 33 || k == 205) m[0] = 1'b1;
    if (k == 200 || k == 214) m = m | 4'b0011;
    if (k >= 70 && k <= 75) m[2] = 1'b1;
    if (k == 140) m = 4'b1111;
    if (k == 170) m = m | 4'b1010;
    if (k == 172 || k == 180) m[3] = 1'b1;
    return m;
  endfunction

  // Sequence started by an event in cycle s: lit at s+1..s+4 and s+8..s+11, busy s+1..s+14.
  function automatic logic [11:0] expect_at(int k);
    logic [3:0] lo;
    logic [3:0] bz;
    logic [3:0] ov;
    lo = '0;
    bz = '0;
    ov = '0;
    foreach (seq_q[i]) begin
      int d;
      d = k - seq_q[i].s;
      if (k <= seq_q[i].e && d >= 1 && d <= 14) begin
        bz[seq_q[i].ch] = 1'b1;
        if (d <= 4 || (d >= 8 && d <= 11)) lo[seq_q[i].ch] = 1'b1;
      end
    end
    if (k == 75 || k == 76) ov[2] = 1'b1;
    return {~lo, bz, ov};
  endfunction

  initial begin
    // Single event, then queued second event on ch0.
    add_seq(0, 5, 1 << 30);
    add_seq(0, 30, 1 << 30);
    add_seq(0, 44, 1 << 30);
    // ch2: one event plus five extras; three queue, two overflow.
    add_seq(2, 70, 1 << 30);
    add_seq(2, 84, 1 << 30);
    add_seq(2, 98, 1 << 30);
    add_seq(2, 112, 1 << 30);
    for (int c = 0; c < 4; c++) add_seq(c, 140, 1 << 30);
    // Reset at cycle 176 cuts ch1/ch3 and clears ch3's queued event.
    add_seq(1, 170, 176);
    add_seq(3, 170, 176);
    add_seq(3, 180, 1 << 30);
    // Live event at the decision cycle: ch1 with empty queue, ch0 with one queued.
    add_seq(1, 200, 1 << 30);
    add_seq(1, 214, 1 << 30);
    add_seq(0, 200, 1 << 30);
    add_seq(0, 214, 1 << 30);
    add_seq(0, 228, 1 << 30);
  end

  // Stimulus: drive inputs just after each rising edge and queue the outputs expected this cycle.
  initial begin
    rst   = 1'b1;
    ev_in = '0;
    for (int k = 0; k < N_CYC; k++) begin
      @(posedge clk);
      #1;
      rst   = rst_at(k);
      ev_in = ev_at(k);
      if (k > 0) begin
        exp_t x;
        x.cyc = k;
        x.val = expect_at(k);
        exp_q.push_back(x);
      end
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expected cycles never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        logic [11:0] got;
        x   = exp_q.pop_front();
        got = {led_n, busy, pend_ovf};
        n_vec++;
        if (got !== x.val) begin
          n_bad++;
          $display("FAIL cycle %0d outputs: led_n=%b busy=%b pend_ovf=%b, expected led_n=%b busy=%b pend_ovf=%b",
                   x.cyc, got[11:8], got[7:4], got[3:0], x.val[11:8], x.val[7:4], x.val[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
